// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - fixed-priority multi-channel interrupt controller feeding the fetch stage
// Edge/level capture, runtime mask, one request at a time with stall/accept/return handshake.
module interrupt_controller #(
    parameter int                 NUM_IRQ   = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}},
    parameter int                 ID_WIDTH  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NUM_IRQ-1:0]  i_irq,
    input  logic                i_mask_we,
    input  logic [NUM_IRQ-1:0]  i_mask_data,
    input  logic                i_stall,
    input  logic                i_accept,
    input  logic                i_return,
    output logic                o_interrupt_call,
    output logic [ID_WIDTH-1:0] o_irq_id,
    output logic [NUM_IRQ-1:0]  o_pending,
    output logic                o_in_service
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_SERVICE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [NUM_IRQ-1:0]   r_pending;
    logic [NUM_IRQ-1:0]   r_mask;
    logic [NUM_IRQ-1:0]   r_prev;
    logic [ID_WIDTH-1:0]  r_irq_id;

    logic [NUM_IRQ-1:0]   w_eligible;
    logic                 w_any_eligible;
    logic [ID_WIDTH-1:0]  w_winner;
    logic                 w_accept_fire;
    logic [NUM_IRQ-1:0]   w_edge_set;
    logic [NUM_IRQ-1:0]   w_accept_clear;
    logic [NUM_IRQ-1:0]   w_pending_next;

    assign w_eligible     = r_pending & r_mask;
    assign w_any_eligible = |w_eligible;
    assign w_accept_fire  = (r_state == S_REQUEST) && i_accept && !i_stall;
    assign w_edge_set     = i_irq & ~r_prev;
    assign w_accept_clear = w_accept_fire ? (NUM_IRQ'(1) << r_irq_id) : '0;

    // A fresh edge beats a same-cycle accept clear; level channels simply follow the line.
    assign w_pending_next = (EDGE_MASK & (w_edge_set | (r_pending & ~w_accept_clear)))
                          | (~EDGE_MASK & i_irq);

    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_any_eligible) w_next_state = S_REQUEST;
            S_REQUEST: if (w_accept_fire)  w_next_state = S_SERVICE;
            S_SERVICE: if (i_return)       w_next_state = S_IDLE;
            default:                       w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending <= '0;
            r_mask    <= '1;
            r_prev    <= '0;
            r_irq_id  <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_prev    <= i_irq;
            if (i_mask_we) begin
                r_mask <= i_mask_data;
            end
            // The id is latched only on entry to REQUEST and then held through SERVICE.
            if (r_state == S_IDLE && w_any_eligible) begin
                r_irq_id <= w_winner;
            end
        end
    end

    assign o_interrupt_call = (r_state == S_REQUEST) && !i_stall;
    assign o_in_service     = (r_state == S_SERVICE);
    assign o_irq_id         = r_irq_id;
    assign o_pending        = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller
module tb_interrupt_controller;

    localparam logic [3:0] EDGE = 4'b1101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_data = '0;
    logic       stall = 1'b0;
    logic       accept = 1'b0;
    logic       ret = 1'b0;
    logic       o_call;
    logic [1:0] o_id;
    logic [3:0] o_pend;
    logic       o_svc;

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_id;
    bit m_pend [4];
    bit m_mask [4];
    bit m_prev [4];

    always #5 clk = ~clk;

    interrupt_controller #(
        .NUM_IRQ   (4),
        .EDGE_MASK (EDGE),
        .ID_WIDTH  (2)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_irq            (irq),
        .i_mask_we        (mask_we),
        .i_mask_data      (mask_data),
        .i_stall          (stall),
        .i_accept         (accept),
        .i_return         (ret),
        .o_interrupt_call (o_call),
        .o_irq_id         (o_id),
        .o_pending        (o_pend),
        .o_in_service     (o_svc)
    );

    task automatic model_reset();
        m_phase = 0;
        m_id    = 0;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0;
            m_mask[i] = 1'b1;
            m_prev[i] = 1'b0;
        end
    endtask

    // Checks current outputs against the model, clocks once, advances the model.
    task automatic cycle();
        logic [3:0] exp_pend;
        logic       exp_call;
        int         winner;
        bit         acc_ok;
        #1;
        for (int i = 0; i < 4; i++) exp_pend[i] = m_pend[i];
        exp_call = (m_phase == 1 && !stall) ? 1'b1 : 1'b0;
        checks++;
        if (o_call !== exp_call) begin
            errors++;
            $display("FAIL call @%0t: got %b expected %b", $time, o_call, exp_call);
        end
        checks++;
        if (o_pend !== exp_pend) begin
            errors++;
            $display("FAIL pending @%0t: got %b expected %b", $time, o_pend, exp_pend);
        end
        checks++;
        if (o_svc !== (m_phase == 2)) begin
            errors++;
            $display("FAIL in_service @%0t: got %b expected %b", $time, o_svc, m_phase == 2);
        end
        checks++;
        if (o_id !== 2'(m_id)) begin
            errors++;
            $display("FAIL irq_id @%0t: got %0d expected %0d", $time, o_id, m_id);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc_ok = (m_phase == 1) && accept && !stall;
            winner = -1;
            for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) winner = i;
            for (int i = 0; i < 4; i++) begin
                if (EDGE[i]) begin
                    if (irq[i] && !m_prev[i])           m_pend[i] = 1'b1;
                    else if (acc_ok && m_id == i)       m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = irq[i];
                end
            end
            case (m_phase)
                0: if (winner >= 0) begin m_id = winner; m_phase = 1; end
                1: if (acc_ok) m_phase = 2;
                default: if (ret) m_phase = 0;
            endcase
            for (int i = 0; i < 4; i++) begin
                if (mask_we) m_mask[i] = mask_data[i];
                m_prev[i] = irq[i];
            end
        end
        @(negedge clk);
        accept  = 1'b0;
        ret     = 1'b0;
        mask_we = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        checks++;
        if (o_pend !== 4'b0000 || o_call !== 1'b0 || o_svc !== 1'b0 || o_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got pend=%b call=%b svc=%b id=%0d expected all 0",
                     o_pend, o_call, o_svc, o_id);
        end
        idle_cycles(3);
    endtask

    task automatic test_edge_basic();
        irq = 4'b0100;
        cycle();
        checks++;
        if (o_pend !== 4'b0100) begin
            errors++;
            $display("FAIL edge_pending: got %b expected 0100", o_pend);
        end
        cycle();
        #1;
        checks++;
        if (o_call !== 1'b1 || o_id !== 2'd2) begin
            errors++;
            $display("FAIL edge_call: got call=%b id=%0d expected call=1 id=2", o_call, o_id);
        end
        accept = 1'b1;
        cycle();
        checks++;
        if (o_svc !== 1'b1 || o_pend !== 4'b0000) begin
            errors++;
            $display("FAIL edge_accept: got svc=%b pend=%b expected svc=1 pend=0000", o_svc, o_pend);
        end
        idle_cycles(4);
        ret = 1'b1;
        cycle();
        checks++;
        if (o_svc !== 1'b0 || o_call !== 1'b0) begin
            errors++;
            $display("FAIL edge_return: got svc=%b call=%b expected 0 0", o_svc, o_call);
        end
        irq = 4'b0000;
        idle_cycles(3);
    endtask

    task automatic test_priority();
        irq = 4'b1010;
        idle_cycles(1);
        irq = 4'b0000;
        idle_cycles(1);
        #1;
        checks++;
        if (o_call !== 1'b1 || o_id !== 2'd1) begin
            errors++;
            $display("FAIL prio_first: got call=%b id=%0d expected call=1 id=1", o_call, o_id);
        end
        accept = 1'b1;
        idle_cycles(3);
        ret = 1'b1;
        idle_cycles(2);
        #1;
        checks++;
        if (o_call !== 1'b1 || o_id !== 2'd3) begin
            errors++;
            $display("FAIL prio_second: got call=%b id=%0d expected call=1 id=3", o_call, o_id);
        end
        accept = 1'b1;
        idle_cycles(2);
        ret = 1'b1;
        idle_cycles(3);
    endtask

    task automatic test_mask();
        mask_we = 1'b1;
        mask_data = 4'b1110;
        cycle();
        irq = 4'b0001;
        idle_cycles(3);
        #1;
        checks++;
        if (o_pend[0] !== 1'b1 || o_call !== 1'b0) begin
            errors++;
            $display("FAIL mask_hold: got pend0=%b call=%b expected 1 0", o_pend[0], o_call);
        end
        mask_we = 1'b1;
        mask_data = 4'b1111;
        idle_cycles(2);
        #1;
        checks++;
        if (o_call !== 1'b1 || o_id !== 2'd0) begin
            errors++;
            $display("FAIL mask_release: got call=%b id=%0d expected call=1 id=0", o_call, o_id);
        end
        accept = 1'b1;
        idle_cycles(2);
        ret = 1'b1;
        irq = 4'b0000;
        idle_cycles(3);
    endtask

    task automatic test_stall();
        irq = 4'b1000;
        idle_cycles(2);
        stall = 1'b1;
        idle_cycles(1);
        accept = 1'b1;
        idle_cycles(2);
        #1;
        checks++;
        if (o_call !== 1'b0 || o_svc !== 1'b0) begin
            errors++;
            $display("FAIL stall_ignore: got call=%b svc=%b expected 0 0", o_call, o_svc);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (o_call !== 1'b1 || o_id !== 2'd3) begin
            errors++;
            $display("FAIL stall_release: got call=%b id=%0d expected call=1 id=3", o_call, o_id);
        end
        accept = 1'b1;
        idle_cycles(2);
        ret = 1'b1;
        irq = 4'b0000;
        idle_cycles(3);
    endtask

    task automatic test_level();
        irq = 4'b0010;
        idle_cycles(2);
        accept = 1'b1;
        idle_cycles(3);
        ret = 1'b1;
        idle_cycles(2);
        #1;
        checks++;
        if (o_call !== 1'b1 || o_id !== 2'd1) begin
            errors++;
            $display("FAIL level_retrigger: got call=%b id=%0d expected call=1 id=1", o_call, o_id);
        end
        accept = 1'b1;
        idle_cycles(1);
        irq = 4'b0000;
        idle_cycles(2);
        ret = 1'b1;
        idle_cycles(3);
        #1;
        checks++;
        if (o_call !== 1'b0 || o_svc !== 1'b0) begin
            errors++;
            $display("FAIL level_dropped: got call=%b svc=%b expected 0 0", o_call, o_svc);
        end
    endtask

    task automatic test_reset_in_service();
        mask_we = 1'b1;
        mask_data = 4'b0110;
        irq = 4'b1010;
        idle_cycles(2);
        accept = 1'b1;
        idle_cycles(2);
        irq = 4'b0000;
        rst = 1'b1;
        cycle();
        checks++;
        if (o_pend !== 4'b0000 || o_call !== 1'b0 || o_svc !== 1'b0 || o_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_service: got pend=%b call=%b svc=%b id=%0d expected all 0",
                     o_pend, o_call, o_svc, o_id);
        end
        idle_cycles(3);
        irq = 4'b1000;
        idle_cycles(2);
        #1;
        checks++;
        if (o_call !== 1'b1 || o_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_mask: got call=%b id=%0d expected call=1 id=3", o_call, o_id);
        end
        accept = 1'b1;
        idle_cycles(1);
        ret = 1'b1;
        irq = 4'b0000;
        idle_cycles(2);
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 4; i++) irq[i] = ($urandom_range(0, 5) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            accept    = ($urandom_range(0, 2) == 0);
            ret       = ($urandom_range(0, 3) == 0);
            mask_we   = ($urandom_range(0, 15) == 0);
            mask_data = 4'($urandom_range(0, 15));
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        stall = 1'b0;
        irq   = 4'b0000;
        idle_cycles(2);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_edge_basic();
        test_priority();
        test_mask();
        test_stall();
        test_level();
        test_reset_in_service();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
